// File: rtl/dual_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the dual-issue control stage: opcode/funct7 constants,
// the instruction class enum, the decoded-instruction struct and the NOP word.
// Optional feature macro used by the top: DUAL_ISSUE_EN.
// -----------------------------------------------------------------------------
package issue_pkg;

    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
    localparam logic [6:0]  OPC_IALU  = 7'b0010011;
    localparam logic [6:0]  F7_MUL    = 7'b0000001;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        CLS_LOAD  = 2'd0,
        CLS_ALU   = 2'd1,
        CLS_MUL   = 2'd2,
        CLS_UNSUP = 2'd3
    } instr_cls_e;

    typedef struct packed {
        instr_cls_e cls;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
    } dec_instr_t;

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// dual_issue_ctrl_if
// Bundle between the instruction queue / execution side and dual_issue_ctrl.
//   instr1, instr2   : queue head and head+1 (queue -> controller)
//   shift_count      : combinational number of instructions consumed (0..2)
//   iss0_valid/instr : registered slot 0 (from instr1)
//   iss1_valid/instr : registered slot 1 (from instr2)
// master = queue/bench side, slave = controller side.
// -----------------------------------------------------------------------------
interface dual_issue_ctrl_if;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [1:0]  shift_count;
    logic        iss0_valid;
    logic [31:0] iss0_instr;
    logic        iss1_valid;
    logic [31:0] iss1_instr;

    modport master (
        output instr1, instr2,
        input  shift_count, iss0_valid, iss0_instr, iss1_valid, iss1_instr
    );

    modport slave (
        input  instr1, instr2,
        output shift_count, iss0_valid, iss0_instr, iss1_valid, iss1_instr
    );
endinterface

// File: rtl/dual_issue_ctrl_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Combinational decoder for one queue slot: classifies the instruction and
// extracts rd/rs1/rs2 with source-used flags. Unsupported opcodes report no
// sources and rd = x0 so they never touch the scoreboard.
//   i_instr : raw 32-bit instruction
//   o_dec   : decoded fields (issue_pkg::dec_instr_t)
// -----------------------------------------------------------------------------
module instr_decode
    import issue_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_instr_t  o_dec
);
    logic [6:0] w_opc;
    logic [6:0] w_f7;
    logic       w_unused_funct3;

    assign w_opc           = i_instr[6:0];
    assign w_f7            = i_instr[31:25];
    assign w_unused_funct3 = ^i_instr[14:12];

    always_comb begin
        o_dec     = '0;
        o_dec.cls = CLS_UNSUP;
        case (w_opc)
            OPC_LOAD: begin
                o_dec.cls      = CLS_LOAD;
                o_dec.rd       = i_instr[11:7];
                o_dec.rs1      = i_instr[19:15];
                o_dec.rs1_used = 1'b1;
            end
            OPC_RTYPE: begin
                o_dec.cls      = (w_f7 == F7_MUL) ? CLS_MUL : CLS_ALU;
                o_dec.rd       = i_instr[11:7];
                o_dec.rs1      = i_instr[19:15];
                o_dec.rs2      = i_instr[24:20];
                o_dec.rs1_used = 1'b1;
                o_dec.rs2_used = 1'b1;
            end
            OPC_IALU: begin
                o_dec.cls      = CLS_ALU;
                o_dec.rd       = i_instr[11:7];
                o_dec.rs1      = i_instr[19:15];
                o_dec.rs1_used = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dual_issue_ctrl.sv
// -----------------------------------------------------------------------------
// dual_issue_ctrl
// Consumer end of the instruction queue. Checks the two head instructions
// against a per-register latency scoreboard (plus a mul-unit busy counter),
// returns how many were consumed and registers them into two issue slots.
// Optional feature macro: DUAL_ISSUE_EN (undefined: slot 1 not built,
// shift_count limited to 0/1, slot 1 tied to invalid NOP).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : dual_issue_ctrl_if.slave (instr1/instr2 in, shift_count and
//           iss0/iss1 valid+instr out)
// Parameters ALU_LAT / LOAD_LAT / MUL_LAT: result latencies, 1..7.
// -----------------------------------------------------------------------------
module dual_issue_ctrl
    import issue_pkg::*;
#(
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MUL_LAT  = 3
) (
    input  logic           clk,
    input  logic           reset,
    dual_issue_ctrl_if.slave bus
);
    dec_instr_t  w_d1;
    dec_instr_t  w_d2;
    logic [31:0] w_rdy;
    logic        w_mul_rdy;
    logic        w_iss1;
    logic        w_iss2;

    logic [2:0]  r_sb [1:31];
    logic [2:0]  r_mul_cnt;
    logic        r_iss0_vld_p1;
    logic [31:0] r_iss0_instr_p1;

    // Ready means the producer result can be forwarded this cycle.
    function automatic logic ops_ready(input dec_instr_t d, input logic [31:0] rdy,
                                       input logic mul_rdy);
        return (!d.rs1_used || rdy[d.rs1]) && (!d.rs2_used || rdy[d.rs2]) &&
               rdy[d.rd] && ((d.cls != CLS_MUL) || mul_rdy);
    endfunction

    function automatic logic [2:0] lat_of(input instr_cls_e c);
        case (c)
            CLS_LOAD: return 3'(LOAD_LAT);
            CLS_MUL:  return 3'(MUL_LAT);
            default:  return 3'(ALU_LAT);
        endcase
    endfunction

    always_comb begin
        w_rdy    = '0;
        w_rdy[0] = 1'b1;
        for (int i = 1; i < 32; i++) begin
            w_rdy[i] = (r_sb[i] <= 3'd1);
        end
    end

    assign w_mul_rdy = (r_mul_cnt <= 3'd1);

    instr_decode u_dec0 (
        .i_instr (bus.instr1),
        .o_dec   (w_d1)
    );

    assign w_iss1 = !reset && ops_ready(w_d1, w_rdy, w_mul_rdy);

`ifdef DUAL_ISSUE_EN
    logic        w_pair_ok;
    logic        r_iss1_vld_p1;
    logic [31:0] r_iss1_instr_p1;

    instr_decode u_dec1 (
        .i_instr (bus.instr2),
        .o_dec   (w_d2)
    );

    // Intra-pair hazards: no forwarding between the two slots of one pair,
    // a single memory port and a single unpipelined multiplier.
    always_comb begin
        w_pair_ok = 1'b1;
        if (w_d1.rd != 5'd0) begin
            if (w_d2.rs1_used && (w_d2.rs1 == w_d1.rd)) w_pair_ok = 1'b0;
            if (w_d2.rs2_used && (w_d2.rs2 == w_d1.rd)) w_pair_ok = 1'b0;
            if (w_d2.rd == w_d1.rd)                     w_pair_ok = 1'b0;
        end
        if ((w_d1.cls == CLS_LOAD) && (w_d2.cls == CLS_LOAD)) w_pair_ok = 1'b0;
        if ((w_d1.cls == CLS_MUL)  && (w_d2.cls == CLS_MUL))  w_pair_ok = 1'b0;
    end

    assign w_iss2 = w_iss1 && (w_d1.cls != CLS_UNSUP) &&
                    ops_ready(w_d2, w_rdy, w_mul_rdy) && w_pair_ok;

    // ---- slot 1 issue register (p1) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss1_vld_p1   <= 1'b0;
            r_iss1_instr_p1 <= NOP_INSTR;
        end else begin
            r_iss1_vld_p1   <= w_iss2;
            r_iss1_instr_p1 <= w_iss2 ? bus.instr2 : NOP_INSTR;
        end
    end

    assign bus.iss1_valid = r_iss1_vld_p1;
    assign bus.iss1_instr = r_iss1_instr_p1;
`else
    logic w_unused_instr2;

    assign w_unused_instr2 = ^bus.instr2;
    assign w_d2            = '0;
    assign w_iss2          = 1'b0;
    assign bus.iss1_valid  = 1'b0;
    assign bus.iss1_instr  = NOP_INSTR;
`endif

    assign bus.shift_count = w_iss2 ? 2'b10 : {1'b0, w_iss1};

    // ---- scoreboard update (state for next cycle) ----
    // A load on issue wins over the per-cycle decrement; the two slots never
    // target the same rd because the pair check rejects that case.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_sb[i] <= 3'd0;
            end
            r_mul_cnt <= 3'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_iss1 && (w_d1.rd == 5'(i))) begin
                    r_sb[i] <= lat_of(w_d1.cls);
                end else if (w_iss2 && (w_d2.rd == 5'(i))) begin
                    r_sb[i] <= lat_of(w_d2.cls);
                end else if (r_sb[i] != 3'd0) begin
                    r_sb[i] <= r_sb[i] - 3'd1;
                end
            end
            if ((w_iss1 && (w_d1.cls == CLS_MUL)) || (w_iss2 && (w_d2.cls == CLS_MUL))) begin
                r_mul_cnt <= 3'(MUL_LAT);
            end else if (r_mul_cnt != 3'd0) begin
                r_mul_cnt <= r_mul_cnt - 3'd1;
            end
        end
    end

    // ---- slot 0 issue register (p1) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss0_vld_p1   <= 1'b0;
            r_iss0_instr_p1 <= NOP_INSTR;
        end else begin
            r_iss0_vld_p1   <= w_iss1;
            r_iss0_instr_p1 <= w_iss1 ? bus.instr1 : NOP_INSTR;
        end
    end

    assign bus.iss0_valid = r_iss0_vld_p1;
    assign bus.iss0_instr = r_iss0_instr_p1;
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_ctrl
// Directed scenarios followed by a randomized instruction stream. The reference
// keeps, per register and for the multiplier, the absolute cycle at which the
// value becomes forwardable, and decides issue from the hazard rules directly.
// -----------------------------------------------------------------------------
module tb_dual_issue_ctrl;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;
    localparam int MUL_LAT  = 3;
    localparam logic [31:0] NOP = 32'h00000013;

    localparam int C_LOAD  = 0;
    localparam int C_ALU   = 1;
    localparam int C_MUL   = 2;
    localparam int C_UNSUP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dual_issue_ctrl_if bus ();

    dual_issue_ctrl #(
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT),
        .MUL_LAT  (MUL_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference state
    longint cyc = 0;
    longint ready_at [32];
    longint mul_at = 0;
    bit          e_known = 1'b0;
    bit          e_v0 = 1'b0, e_v1 = 1'b0;
    logic [31:0] e_i0 = NOP, e_i1 = NOP;
    int          last_n = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void mdec(input logic [31:0] x, output int cls, output int rd,
                                 output bit u1, output int r1, output bit u2, output int r2);
        cls = C_UNSUP; rd = 0; u1 = 0; r1 = 0; u2 = 0; r2 = 0;
        if (x[6:0] == 7'b0000011) begin
            cls = C_LOAD; rd = int'(x[11:7]); u1 = 1; r1 = int'(x[19:15]);
        end else if (x[6:0] == 7'b0110011) begin
            cls = (x[31:25] == 7'b0000001) ? C_MUL : C_ALU;
            rd = int'(x[11:7]); u1 = 1; r1 = int'(x[19:15]); u2 = 1; r2 = int'(x[24:20]);
        end else if (x[6:0] == 7'b0010011) begin
            cls = C_ALU; rd = int'(x[11:7]); u1 = 1; r1 = int'(x[19:15]);
        end
    endfunction

    function automatic bit rdy(input int r);
        return (r == 0) || (cyc >= ready_at[r]);
    endfunction

    function automatic int lat(input int cls);
        if (cls == C_LOAD) return LOAD_LAT;
        if (cls == C_MUL)  return MUL_LAT;
        return ALU_LAT;
    endfunction

    function automatic bit alone_ok(input int c, input int d, input bit ua, input int sa,
                                    input bit ub, input int sb);
        return (!ua || rdy(sa)) && (!ub || rdy(sb)) && rdy(d) && (c != C_MUL || cyc >= mul_at);
    endfunction

    function automatic int model_count(input logic [31:0] a, input logic [31:0] b);
        int c1, d1, s1a, s1b, c2, d2, s2a, s2b;
        bit u1a, u1b, u2a, u2b, ok2;
        mdec(a, c1, d1, u1a, s1a, u1b, s1b);
        if (!alone_ok(c1, d1, u1a, s1a, u1b, s1b)) return 0;
`ifdef DUAL_ISSUE_EN
        if (c1 == C_UNSUP) return 1;
        mdec(b, c2, d2, u2a, s2a, u2b, s2b);
        ok2 = alone_ok(c2, d2, u2a, s2a, u2b, s2b);
        if (d1 != 0 && ((u2a && s2a == d1) || (u2b && s2b == d1) || d2 == d1)) ok2 = 0;
        if (c1 == C_LOAD && c2 == C_LOAD) ok2 = 0;
        if (c1 == C_MUL && c2 == C_MUL) ok2 = 0;
        return ok2 ? 2 : 1;
`else
        c2 = 0; d2 = 0; s2a = 0; s2b = 0; u2a = 0; u2b = 0; ok2 = 0;
        if (b == 32'h0) return 1;
        return 1;
`endif
    endfunction

    function automatic void commit_one(input logic [31:0] x);
        int c, d, sa, sb;
        bit ua, ub;
        mdec(x, c, d, ua, sa, ub, sb);
        if (d != 0) ready_at[d] = cyc + lat(c);
        if (c == C_MUL) mul_at = cyc + MUL_LAT;
    endfunction

    // One clock: compare at negedge, advance reference, return #1 after posedge.
    task automatic tick(output int obs);
        int n;
        @(negedge clk);
        n = reset ? 0 : model_count(bus.instr1, bus.instr2);
        check("shift_count", {30'd0, bus.shift_count}, 32'(n));
        if (e_known) begin
            check("iss0_valid", {31'd0, bus.iss0_valid}, {31'd0, e_v0});
            check("iss1_valid", {31'd0, bus.iss1_valid}, {31'd0, e_v1});
            if (e_v0) check("iss0_instr", bus.iss0_instr, e_i0);
`ifdef DUAL_ISSUE_EN
            if (e_v1) check("iss1_instr", bus.iss1_instr, e_i1);
`else
            check("iss1_instr_tie", bus.iss1_instr, NOP);
`endif
        end
        obs    = int'(bus.shift_count);
        last_n = n;
        if (reset) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
            mul_at = 0;
            e_v0 = 0; e_v1 = 0; e_i0 = NOP; e_i1 = NOP;
        end else begin
            e_v0 = (n >= 1); e_i0 = (n >= 1) ? bus.instr1 : NOP;
            e_v1 = (n == 2); e_i1 = (n == 2) ? bus.instr2 : NOP;
            if (n >= 1) commit_one(bus.instr1);
            if (n == 2) commit_one(bus.instr2);
        end
        e_known = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        int o;
        reset = 1'b1;
        tick(o);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd  = 5'($urandom_range(0, 3));
        logic [4:0] rs1 = 5'($urandom_range(0, 3));
        logic [4:0] rs2 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0: return {12'($urandom), rs1, 3'b010, rd, 7'b0000011};
            1: return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            2: return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
            3: return {12'($urandom), rs1, 3'b000, rd, 7'b0010011};
            4: return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            default: return {25'($urandom), 7'b1100011};
        endcase
    endfunction

    initial begin
        int obs;
        logic [31:0] q [$];
        for (int r = 0; r < 32; r++) ready_at[r] = 0;

        // reset held two cycles with arbitrary inputs
        reset = 1'b1;
        bus.instr1 = 32'h02728133;
        bus.instr2 = 32'h0f002103;
        tick(obs);
        check("t1_rst_sc_a", 32'(obs), 32'd0);
        bus.instr1 = 32'h007280b3;
        tick(obs);
        check("t1_rst_sc_b", 32'(obs), 32'd0);
        check("t1_iss0_valid", {31'd0, bus.iss0_valid}, 32'd0);
        check("t1_iss1_valid", {31'd0, bus.iss1_valid}, 32'd0);
        reset = 1'b0;

        // two loads cannot pair
        bus.instr1 = 32'h24402083;
        bus.instr2 = 32'h0f002103;
        tick(obs);
        check("t2_sc", 32'(obs), 32'd1);
        check("t2_iss0_instr", bus.iss0_instr, 32'h24402083);
        check("t2_iss1_valid", {31'd0, bus.iss1_valid}, 32'd0);

        // intra-pair RAW, then the dependent issues next cycle
        do_reset();
        bus.instr1 = 32'h007280b3;
        bus.instr2 = 32'h005080b3;
        tick(obs);
        check("t3_sc", 32'(obs), 32'd1);
        bus.instr1 = 32'h005080b3;
        bus.instr2 = NOP;
        tick(obs);
        check("t3_next_issues", 32'(obs >= 1), 32'd1);

        // load-use stall of one cycle
        do_reset();
        bus.instr1 = 32'h24402083;
        bus.instr2 = 32'h0f002103;
        tick(obs);
        check("t4_lw", 32'(obs), 32'd1);
        bus.instr1 = 32'h000081b3;
        bus.instr2 = NOP;
        tick(obs);
        check("t4_stall", 32'(obs), 32'd0);
        tick(obs);
        check("t4_go", 32'(obs >= 1), 32'd1);

        // unpipelined multiplier: busy counter loaded with MUL_LAT
        do_reset();
        bus.instr1 = 32'h02728133;
        bus.instr2 = 32'h02728333;
        tick(obs);
        check("t5_mul_pair", 32'(obs), 32'd1);
        bus.instr1 = 32'h02728333;
        bus.instr2 = NOP;
        tick(obs);
        check("t5_busy", 32'(obs), 32'd0);
        tick(obs);
        tick(obs);
        check("t5_go", 32'(obs >= 1), 32'd1);

        // independent ALU + NOP
        do_reset();
        bus.instr1 = 32'h007280b3;
        bus.instr2 = NOP;
        tick(obs);
`ifdef DUAL_ISSUE_EN
        check("t6_sc", 32'(obs), 32'd2);
        check("t6_iss1_valid", {31'd0, bus.iss1_valid}, 32'd1);
`else
        check("t6_sc", 32'(obs), 32'd1);
        check("t6_iss1_valid", {31'd0, bus.iss1_valid}, 32'd0);
`endif
        check("t6_iss0_valid", {31'd0, bus.iss0_valid}, 32'd1);

        // randomized stream consumed queue-style
        for (int k = 0; k < 3000; k++) begin
            while (q.size() < 2) q.push_back(rand_instr());
            reset = ($urandom_range(0, 59) == 0);
            bus.instr1 = q[0];
            bus.instr2 = q[1];
            tick(obs);
            for (int p = 0; p < last_n; p++) void'(q.pop_front());
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
